// File: rtl/clock_ctrl_pkg.sv
// Shared state encoding, BCD limits and helpers for the clock set-mode controller.
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SET_HH = 2'd1,
        SET_MM = 2'd2
    } set_state_e;

    localparam logic [7:0] HH_MIN     = 8'h01;
    localparam logic [7:0] HH_MAX     = 8'h12;
    localparam logic [7:0] MM_MIN     = 8'h00;
    localparam logic [7:0] MM_MAX     = 8'h59;
    localparam logic [7:0] SS_ZERO    = 8'h00;
    // Stepping the hour off 11 crosses noon/midnight, so AM/PM flips there.
    localparam logic [7:0] HH_PM_FLIP = 8'h11;

    localparam int PRESC_W = 16;

    function automatic logic bcd_digits_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Signal bundle between the set-mode controller and its timekeeping counter / button front end.
interface clock_set_ctrl_if;

    // Strobe semantics: mode_btn/inc_btn are one-cycle pulses sampled on the rising
    // edge; ena and load are one-cycle registered pulses that are never high together,
    // and ld_* is meaningful whenever load=1 (and mirrors the edit during set modes).
    logic       mode_btn;
    logic       inc_btn;
    logic       cur_pm;
    logic [7:0] cur_hh;
    logic [7:0] cur_mm;
    logic [7:0] cur_ss;

    logic       ena;
    logic       load;
    logic       ld_pm;
    logic [7:0] ld_hh;
    logic [7:0] ld_mm;
    logic [7:0] ld_ss;
    logic [1:0] set_state;

    modport slave (
        input  mode_btn, inc_btn, cur_pm, cur_hh, cur_mm, cur_ss,
        output ena, load, ld_pm, ld_hh, ld_mm, ld_ss, set_state
    );

    modport master (
        output mode_btn, inc_btn, cur_pm, cur_hh, cur_mm, cur_ss,
        input  ena, load, ld_pm, ld_hh, ld_mm, ld_ss, set_state
    );

endinterface

// File: rtl/clock_set_ctrl_bcd2_inc.sv
// Two-digit BCD increment with min/max wrap; out-of-range inputs snap to a fallback value.
module bcd2_inc
    import clock_ctrl_pkg::*;
(
    input  logic [7:0] i_val,
    input  logic [7:0] i_min,
    input  logic [7:0] i_max,
    input  logic [7:0] i_fallback,
    output logic [7:0] o_next
);

    logic w_legal;

    always_comb begin
        w_legal = bcd_digits_ok(i_val) && (i_val >= i_min) && (i_val <= i_max);
        o_next  = i_fallback;
        if (w_legal) begin
            if (i_val == i_max) begin
                o_next = i_min;
            end else if (i_val[3:0] == 4'd9) begin
                o_next = {i_val[7:4] + 4'd1, 4'd0};
            end else begin
                o_next = {i_val[7:4], i_val[3:0] + 4'd1};
            end
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Set-mode controller for a 12-hour BCD clock: one-second prescaler in RUN, hour/minute
// editing via mode/inc buttons, and a single load strobe when the edit is committed.
module clock_set_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1000
) (
    input logic            clk,
    input logic            reset_n,
    clock_set_ctrl_if.slave bus
);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    set_state_e         r_state;
    set_state_e         w_state_nx;
    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] w_presc_nx;
    logic               r_ena;
    logic               w_ena_nx;
    logic               r_load;
    logic               w_load_nx;
    logic               r_pm;
    logic               w_pm_nx;
    logic [7:0]         r_hh;
    logic [7:0]         w_hh_nx;
    logic [7:0]         r_mm;
    logic [7:0]         w_mm_nx;
    logic [7:0]         r_ss;
    logic [7:0]         w_ss_nx;
    logic [7:0]         w_hh_inc;
    logic [7:0]         w_mm_inc;

    // Illegal hours snap to 12, illegal minutes to 00.
    bcd2_inc u_hh_inc (
        .i_val      (r_hh),
        .i_min      (HH_MIN),
        .i_max      (HH_MAX),
        .i_fallback (HH_MAX),
        .o_next     (w_hh_inc)
    );

    bcd2_inc u_mm_inc (
        .i_val      (r_mm),
        .i_min      (MM_MIN),
        .i_max      (MM_MAX),
        .i_fallback (MM_MIN),
        .o_next     (w_mm_inc)
    );

    always_comb begin
        w_state_nx = r_state;
        w_presc_nx = r_presc;
        w_ena_nx   = 1'b0;
        w_load_nx  = 1'b0;
        w_pm_nx    = r_pm;
        w_hh_nx    = r_hh;
        w_mm_nx    = r_mm;
        w_ss_nx    = r_ss;

        case (r_state)
            RUN: begin
                if (bus.mode_btn) begin
                    w_state_nx = SET_HH;
                    w_presc_nx = '0;
                    w_pm_nx    = bus.cur_pm;
                    w_hh_nx    = bus.cur_hh;
                    w_mm_nx    = bus.cur_mm;
                    w_ss_nx    = bus.cur_ss;
                end else if (r_presc == PRESC_LAST) begin
                    w_ena_nx   = 1'b1;
                    w_presc_nx = '0;
                end else begin
                    w_presc_nx = r_presc + PRESC_W'(1);
                end
            end

            SET_HH: begin
                if (bus.mode_btn) begin
                    w_state_nx = SET_MM;
                end else if (bus.inc_btn) begin
                    w_hh_nx = w_hh_inc;
                    if (r_hh == HH_PM_FLIP) begin
                        w_pm_nx = ~r_pm;
                    end
                end
            end

            SET_MM: begin
                // Commit: load fires with the prescaler restarting from 0 alongside it.
                if (bus.mode_btn) begin
                    w_state_nx = RUN;
                    w_load_nx  = 1'b1;
                    w_ss_nx    = SS_ZERO;
                    w_presc_nx = '0;
                end else if (bus.inc_btn) begin
                    w_mm_nx = w_mm_inc;
                end
            end

            default: begin
                w_state_nx = RUN;
                w_presc_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RUN;
            r_presc <= '0;
            r_ena   <= 1'b0;
            r_load  <= 1'b0;
            r_pm    <= 1'b0;
            r_hh    <= HH_MAX;
            r_mm    <= MM_MIN;
            r_ss    <= SS_ZERO;
        end else begin
            r_state <= w_state_nx;
            r_presc <= w_presc_nx;
            r_ena   <= w_ena_nx;
            r_load  <= w_load_nx;
            r_pm    <= w_pm_nx;
            r_hh    <= w_hh_nx;
            r_mm    <= w_mm_nx;
            r_ss    <= w_ss_nx;
        end
    end

    assign bus.ena       = r_ena;
    assign bus.load      = r_load;
    assign bus.ld_pm     = r_pm;
    assign bus.ld_hh     = r_hh;
    assign bus.ld_mm     = r_mm;
    assign bus.ld_ss     = r_ss;
    assign bus.set_state = r_state;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: per-cycle scoreboard against an arithmetic time model,
// directed scenarios for cadence/edit/commit/reset, then randomized button traffic.
module tb_clock_set_ctrl;

    localparam int unsigned TICK_DIV = 4;
    localparam int SNAP_W = 29;

    logic clk;
    logic reset_n;

    clock_set_ctrl_if bus ();

    clock_set_ctrl #(.TICK_DIV(TICK_DIV)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [SNAP_W-1:0] exp_q[$];

    // Reference model: mode 0=RUN 1=SET_HH 2=SET_MM, time kept as raw bytes,
    // tick cadence from the count of edges since reset release or load.
    int unsigned m_mode;
    logic        m_pm;
    logic [7:0]  m_hh;
    logic [7:0]  m_mm;
    logic [7:0]  m_ss;
    int unsigned m_cnt;

    logic       cur_pm_v;
    logic [7:0] cur_hh_v;
    logic [7:0] cur_mm_v;
    logic [7:0] cur_ss_v;

    function automatic int bcd_val(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic is_bcd(input logic [7:0] b);
        return (b[7:4] < 4'd10) && (b[3:0] < 4'd10);
    endfunction

    task automatic model_step(input logic mode, input logic inc, input logic rstn,
                              output logic [SNAP_W-1:0] snap);
        logic e;
        logic l;
        int   h;
        e = 1'b0;
        l = 1'b0;
        if (!rstn) begin
            m_mode = 0; m_pm = 1'b0; m_hh = 8'h12; m_mm = 8'h00; m_ss = 8'h00; m_cnt = 0;
        end else if (m_mode == 0) begin
            if (mode) begin
                m_mode = 1;
                m_pm = cur_pm_v; m_hh = cur_hh_v; m_mm = cur_mm_v; m_ss = cur_ss_v;
            end else begin
                m_cnt = m_cnt + 1;
                e = ((m_cnt % TICK_DIV) == 0);
            end
        end else if (m_mode == 1) begin
            if (mode) begin
                m_mode = 2;
            end else if (inc) begin
                h = bcd_val(m_hh);
                if (is_bcd(m_hh) && h >= 1 && h <= 12) begin
                    if (h == 11) m_pm = ~m_pm;
                    m_hh = to_bcd((h == 12) ? 1 : h + 1);
                end else begin
                    m_hh = 8'h12;
                end
            end
        end else begin
            if (mode) begin
                m_mode = 0; l = 1'b1; m_ss = 8'h00; m_cnt = 0;
            end else if (inc) begin
                h = bcd_val(m_mm);
                if (is_bcd(m_mm) && h <= 59) m_mm = to_bcd((h + 1) % 60);
                else m_mm = 8'h00;
            end
        end
        snap = {e, l, m_pm, m_hh, m_mm, m_ss, 2'(m_mode)};
    endtask

    task automatic set_cur(input logic pm, input logic [7:0] hh, input logic [7:0] mm,
                           input logic [7:0] ss);
        cur_pm_v = pm; cur_hh_v = hh; cur_mm_v = mm; cur_ss_v = ss;
        bus.cur_pm = pm; bus.cur_hh = hh; bus.cur_mm = mm; bus.cur_ss = ss;
    endtask

    task automatic random_cur();
        if ($urandom_range(0, 7) == 0) begin
            set_cur(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end else begin
            set_cur(1'($urandom_range(0, 1)), to_bcd(int'($urandom_range(1, 12))),
                    to_bcd(int'($urandom_range(0, 59))), to_bcd(int'($urandom_range(0, 59))));
        end
    endtask

    // Inputs change just after a falling edge; the monitor samples on the falling edge.
    task automatic step(input logic mode, input logic inc, input logic rstn);
        logic [SNAP_W-1:0] s;
        bus.mode_btn = mode;
        bus.inc_btn  = inc;
        reset_n      = rstn;
        model_step(mode, inc, rstn, s);
        exp_q.push_back(s);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    logic [SNAP_W-1:0] mon_exp;
    logic [SNAP_W-1:0] mon_act;

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                mon_act = {bus.ena, bus.load, bus.ld_pm, bus.ld_hh, bus.ld_mm, bus.ld_ss,
                           bus.set_state};
                n_checks++;
                if (mon_act !== mon_exp) begin
                    n_fail++;
                    $display("FAIL snapshot t=%0t actual ena=%b load=%b pm=%b %h:%h:%h st=%0d required ena=%b load=%b pm=%b %h:%h:%h st=%0d",
                             $time, mon_act[28], mon_act[27], mon_act[26], mon_act[25:18],
                             mon_act[17:10], mon_act[9:2], mon_act[1:0], mon_exp[28],
                             mon_exp[27], mon_exp[26], mon_exp[25:18], mon_exp[17:10],
                             mon_exp[9:2], mon_exp[1:0]);
                end
            end
        end
    end

    logic [11:0] pat12;
    logic [3:0]  pat4;
    logic        load_seen;

    initial begin
        reset_n = 1'b0;
        bus.mode_btn = 1'b0;
        bus.inc_btn  = 1'b0;
        set_cur(1'b0, 8'h12, 8'h00, 8'h00);
        m_mode = 0; m_pm = 1'b0; m_hh = 8'h12; m_mm = 8'h00; m_ss = 8'h00; m_cnt = 0;

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        check("reset_ld", {bus.ld_pm, bus.ld_hh, bus.ld_mm, bus.ld_ss}, {1'b0, 8'h12, 8'h00, 8'h00});
        check("reset_strobes", {bus.ena, bus.load, bus.set_state}, 4'b0000);

        // Idle cadence after release.
        load_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 1'b1);
            pat12[i] = bus.ena;
            load_seen = load_seen | bus.load;
        end
        check("ena_cadence", pat12, 12'b1000_1000_1000);
        check("idle_no_load", load_seen, 1'b0);

        // 11:58:30 PM, hour edit across noon/midnight.
        set_cur(1'b1, 8'h11, 8'h58, 8'h30);
        step(1'b1, 1'b0, 1'b1);
        check("enter_set_hh", bus.set_state, 2'd1);
        step(1'b0, 1'b1, 1'b1);
        check("hh_11_to_12", {bus.ld_pm, bus.ld_hh}, {1'b0, 8'h12});
        step(1'b0, 1'b1, 1'b1);
        check("hh_12_to_01", {bus.ld_pm, bus.ld_hh}, {1'b0, 8'h01});

        // Minute edit with wrap.
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        check("mm_59", bus.ld_mm, 8'h59);
        step(1'b0, 1'b1, 1'b1);
        check("mm_00", bus.ld_mm, 8'h00);
        step(1'b0, 1'b1, 1'b1);
        check("mm_01_hh_kept", {bus.ld_mm, bus.ld_hh}, {8'h01, 8'h01});

        // Commit.
        step(1'b1, 1'b0, 1'b1);
        check("commit", {bus.load, bus.ena, bus.ld_ss, bus.set_state}, {1'b1, 1'b0, 8'h00, 2'd0});
        load_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1);
            pat4[i] = bus.ena;
            load_seen = load_seen | bus.load;
        end
        check("ena_after_load", pat4, 4'b1000);
        check("load_single", load_seen, 1'b0);

        // mode and inc together in SET_HH.
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        check("mode_wins", {bus.set_state, bus.ld_hh}, {2'd2, 8'h11});

        // Reset mid-edit.
        step(1'b0, 1'b0, 1'b0);
        load_seen = bus.load;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1);
            pat4[i] = bus.ena;
            load_seen = load_seen | bus.load;
        end
        check("reset_abandon", {bus.set_state, bus.ld_pm, bus.ld_hh, bus.ld_mm, bus.ld_ss},
              {2'd0, 1'b0, 8'h12, 8'h00, 8'h00});
        check("reset_no_load", load_seen, 1'b0);
        check("ena_after_reset", pat4, 4'b1000);

        // Illegal shadow values snap on increment.
        set_cur(1'b0, 8'h1A, 8'h7F, 8'h45);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        check("hh_illegal", {bus.ld_pm, bus.ld_hh}, {1'b0, 8'h12});
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        check("mm_illegal", bus.ld_mm, 8'h00);
        step(1'b1, 1'b0, 1'b1);

        // Randomized traffic, including inc in RUN and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) random_cur();
            step(($urandom_range(0, 99) < 10), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 299) != 0));
        end

        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
